// File: rtl/gb_pkg.sv
// Shared encodings for the gray-balance map generator: FSM states and mode values.
package gb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } gb_state_e;

    localparam logic MODE_OCC = 1'b0;
    localparam logic MODE_CDF = 1'b1;

endpackage

// File: rtl/gb_map_gen_if.sv
// Bundle of upstream control, histogram RAM, divider and map RAM signals of gb_map_gen.
interface gb_map_gen_if #(
    parameter int DIN_WIDTH  = 14,
    parameter int DOUT_WIDTH = 10,
    parameter int CNT_WIDTH  = 22
);
    logic                            aft_valid;
    logic                            aft_endofpacket;
    logic                            mode;
    logic [CNT_WIDTH-1:0]            hist_total;
    logic [CNT_WIDTH-1:0]            clip_limit;
    logic [DIN_WIDTH-1:0]            gray_ram_read_addr;
    logic [CNT_WIDTH-1:0]            gray_ram_read_q;
    logic [DIN_WIDTH-1:0]            gray_ram_write_addr;
    logic                            gray_ram_write;
    logic [CNT_WIDTH+DOUT_WIDTH-1:0] div_numer;
    logic [CNT_WIDTH-1:0]            div_denom;
    logic [DOUT_WIDTH-1:0]           div_quotient;
    logic [DIN_WIDTH-1:0]            map_ram_write_addr;
    logic [DOUT_WIDTH-1:0]           map_ram_write_data;
    logic                            map_ram_write;
    logic                            busy;
    logic                            done;

    modport master (
        input  aft_valid, aft_endofpacket, mode, hist_total, clip_limit,
               gray_ram_read_q, div_quotient,
        output gray_ram_read_addr, gray_ram_write_addr, gray_ram_write,
               div_numer, div_denom, map_ram_write_addr, map_ram_write_data,
               map_ram_write, busy, done
    );

    modport slave (
        output aft_valid, aft_endofpacket, mode, hist_total, clip_limit,
               gray_ram_read_q, div_quotient,
        input  gray_ram_read_addr, gray_ram_write_addr, gray_ram_write,
               div_numer, div_denom, map_ram_write_addr, map_ram_write_data,
               map_ram_write, busy, done
    );

endinterface

// File: rtl/gb_delay_line.sv
// Fixed-depth shift register used to align addresses and valids with RAM/divider latency.
module gb_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gb_map_gen.sv
// Gray-balance map generator: on end-of-frame walks the histogram, builds a rounded CDF map.
// Define GB_MAP_CLIP_EN to clamp each CDF-mode bin contribution to clip_limit.
module gb_map_gen
    import gb_pkg::*;
#(
    parameter int DIN_WIDTH   = 14,
    parameter int DOUT_WIDTH  = 10,
    parameter int CNT_WIDTH   = 22,
    parameter int RD_LATENCY  = 2,
    parameter int DIV_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    gb_map_gen_if.master bus
);

    localparam int NUMER_W    = CNT_WIDTH + DOUT_WIDTH;
    localparam int WR_DEPTH   = RD_LATENCY + 1 + DIV_LATENCY;
    localparam int DRAIN_LAST = RD_LATENCY + DIV_LATENCY;
    localparam int DRAIN_W    = $clog2(DRAIN_LAST + 1) + 1;
    localparam int MAP_MAX    = (1 << DOUT_WIDTH) - 1;

    function automatic logic [CNT_WIDTH-1:0] bin_inc(input logic                 m,
                                                     input logic [CNT_WIDTH-1:0] q,
                                                     input logic [CNT_WIDTH-1:0] limit);
        if (m == MODE_OCC) begin
            return (q != '0) ? CNT_WIDTH'(1) : '0;
        end
        return (q > limit) ? limit : q;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // acc*(2^DOUT-1) + total/2 cannot overflow NUMER_W bits for any CNT_WIDTH-bit operands.
    function automatic logic [NUMER_W-1:0] scale_round(input logic [CNT_WIDTH-1:0] acc,
                                                       input logic [CNT_WIDTH-1:0] total);
        return NUMER_W'(acc) * NUMER_W'(MAP_MAX) + NUMER_W'(total >> 1);
    endfunction

    gb_state_e              state_q, state_d;
    logic [DIN_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   total_q, total_d;
    logic [CNT_WIDTH-1:0]   acc_q, acc_d;
    logic [NUMER_W-1:0]     div_numer_q, div_numer_d;
    logic [CNT_WIDTH-1:0]   clip_val;

    logic                   vld_p0;
    logic                   vld_p1;
    logic                   vld_p3;
    logic [DIN_WIDTH-1:0]   addr_p3;

`ifdef GB_MAP_CLIP_EN
    assign clip_val = bus.clip_limit;
`else
    logic unused_clip;
    assign unused_clip = ^bus.clip_limit;
    assign clip_val    = '1;
`endif

    // Stage p0: read issue; p1: histogram data returns; p2: accumulate; p3: map/clear write.
    assign vld_p0 = (state_q == ST_RUN);

    gb_delay_line #(.WIDTH(1), .DEPTH(RD_LATENCY)) u_rd_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vld_p0),
        .dout  (vld_p1)
    );

    gb_delay_line #(.WIDTH(DIN_WIDTH + 1), .DEPTH(WR_DEPTH)) u_wr_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({vld_p0, rd_addr_q}),
        .dout  ({vld_p3, addr_p3})
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        drain_cnt_d = drain_cnt_q;
        mode_d      = mode_q;
        total_d     = total_q;
        acc_d       = acc_q;
        div_numer_d = div_numer_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.aft_valid && bus.aft_endofpacket) begin
                    state_d   = ST_RUN;
                    rd_addr_d = '0;
                    mode_d    = bus.mode;
                    total_d   = bus.hist_total;
                    acc_d     = '0;
                end
            end
            ST_RUN: begin
                // Hold at all-ones after the last issue so there is never a second pass.
                if (rd_addr_q == '1) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (vld_p1) begin
            acc_d       = sat_add(acc_q, bin_inc(mode_q, bus.gray_ram_read_q, clip_val));
            div_numer_d = scale_round(acc_d, total_q);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_numer_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_numer_q <= div_numer_d;
        end
    end

    always_ff @(posedge clk) begin
        mode_q  <= mode_d;
        total_q <= total_d;
        acc_q   <= acc_d;
    end

    // Quotient is already DOUT_WIDTH wide, so it never exceeds the map maximum.
    assign bus.map_ram_write_data  = (total_q == '0) ? '0 : bus.div_quotient;
    assign bus.map_ram_write_addr  = addr_p3;
    assign bus.map_ram_write       = vld_p3;
    assign bus.gray_ram_write_addr = addr_p3;
    assign bus.gray_ram_write      = vld_p3;
    assign bus.gray_ram_read_addr  = rd_addr_q;
    assign bus.div_numer           = div_numer_q;
    assign bus.div_denom           = total_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;

endmodule

// File: tb/tb_gb_map_gen.sv
// Directed bench for gb_map_gen with histogram RAM, divider and map RAM models (DIN_WIDTH=4).
module tb_gb_map_gen;

    localparam int DIN  = 4;
    localparam int DOUT = 10;
    localparam int CNT  = 22;
    localparam int RD   = 2;
    localparam int DIV  = 4;
    localparam int N    = 1 << DIN;
    localparam int DONE_CYC = N + RD + DIV + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gb_map_gen_if #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT), .CNT_WIDTH(CNT)) bus ();

    gb_map_gen #(
        .DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT), .CNT_WIDTH(CNT),
        .RD_LATENCY(RD), .DIV_LATENCY(DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [CNT-1:0]  hist_mem  [N];
    logic [CNT-1:0]  hist_init [N];
    logic            load_req = 1'b0;
    logic [CNT-1:0]  rd_p1, rd_p2;
    logic [DOUT-1:0] map_mem   [N];
    logic [DOUT-1:0] exp_map   [N];
    logic [DOUT-1:0] div_pipe  [DIV];
    int map_wr_cnt = 0;
    int done_cnt   = 0;
    int n_checks   = 0;
    int n_errors   = 0;

    function automatic logic [DOUT-1:0] div_model(input logic [CNT+DOUT-1:0] n,
                                                  input logic [CNT-1:0] d);
        logic [CNT+DOUT-1:0] qq;
        if (d == '0) return '1;
        qq = n / (CNT+DOUT)'(d);
        return (qq > (CNT+DOUT)'(1023)) ? '1 : qq[DOUT-1:0];
    endfunction

    always @(posedge clk) begin
        rd_p1 <= hist_mem[bus.gray_ram_read_addr];
        rd_p2 <= rd_p1;
        if (load_req) begin
            for (int i = 0; i < N; i++) hist_mem[i] <= hist_init[i];
        end else if (bus.gray_ram_write) begin
            hist_mem[bus.gray_ram_write_addr] <= '0;
        end
        div_pipe[0] <= div_model(bus.div_numer, bus.div_denom);
        for (int i = 1; i < DIV; i++) div_pipe[i] <= div_pipe[i-1];
        if (bus.map_ram_write) begin
            map_mem[bus.map_ram_write_addr] <= bus.map_ram_write_data;
            map_wr_cnt <= map_wr_cnt + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    assign bus.gray_ram_read_q = rd_p2;
    assign bus.div_quotient    = div_pipe[DIV-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_hist();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic start_frame(input logic m, input logic [CNT-1:0] total, input logic [CNT-1:0] clip);
        @(negedge clk);
        bus.mode            = m;
        bus.hist_total      = total;
        bus.clip_limit      = clip;
        bus.aft_valid       = 1'b1;
        bus.aft_endofpacket = 1'b1;
        @(negedge clk);
        bus.aft_valid       = 1'b0;
        bus.aft_endofpacket = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cycles);
        cycles = c0;
        while (bus.done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_map(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_map[%0d]", tag, i), 64'(map_mem[i]), 64'(exp_map[i]));
        end
    endtask

    task automatic check_hist_clear(input string tag);
        logic [CNT-1:0] any;
        any = '0;
        for (int i = 0; i < N; i++) any = any | hist_mem[i];
        check($sformatf("%s_hist_cleared", tag), 64'(any), 64'd0);
    endtask

    task automatic set_occ_pattern();
        for (int i = 0; i < N; i++) hist_init[i] = '0;
        hist_init[3] = 22'd7;
        hist_init[5] = 22'd2;
        hist_init[9] = 22'd1;
        for (int i = 0; i < N; i++) begin
            exp_map[i] = (i < 3) ? 10'd0 : (i < 5) ? 10'd341 : (i < 9) ? 10'd682 : 10'd1023;
        end
    endtask

    initial begin
        int cyc;
        int wr0;
        int dn0;
        int guard;
        bus.aft_valid       = 1'b0;
        bus.aft_endofpacket = 1'b0;
        bus.mode            = 1'b0;
        bus.hist_total      = '0;
        bus.clip_limit      = '0;
        for (int i = 0; i < N; i++) hist_init[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_map_write", 64'(bus.map_ram_write), 64'd0);
        check("rst_clear_write", 64'(bus.gray_ram_write), 64'd0);
        check("rst_numer", 64'(bus.div_numer), 64'd0);
        check("rst_read_addr", 64'(bus.gray_ram_read_addr), 64'd0);
        rst_n = 1'b1;

        // Occupancy mode, bins 3/5/9 nonzero.
        set_occ_pattern();
        load_hist();
        wr0 = map_wr_cnt; dn0 = done_cnt;
        start_frame(1'b0, 22'd3, 22'd0);
        check("occ_busy_start", 64'(bus.busy), 64'd1);
        check("occ_first_addr", 64'(bus.gray_ram_read_addr), 64'd0);
        wait_done(1, cyc);
        check("occ_done_cycles", 64'(cyc), 64'(DONE_CYC));
        @(negedge clk);
        check("occ_busy_after", 64'(bus.busy), 64'd0);
        check("occ_writes", 64'(map_wr_cnt - wr0), 64'(N));
        check("occ_done_pulses", 64'(done_cnt - dn0), 64'd1);
        check_map("occ");
        check_hist_clear("occ");

        // CDF mode, all 16 pixels in bin 7; second eop and input changes during busy.
        for (int i = 0; i < N; i++) hist_init[i] = '0;
        hist_init[7] = 22'd16;
        for (int i = 0; i < N; i++) begin
`ifdef GB_MAP_CLIP_EN
            exp_map[i] = (i < 7) ? 10'd0 : 10'd256;
`else
            exp_map[i] = (i < 7) ? 10'd0 : 10'd1023;
`endif
        end
        load_hist();
        wr0 = map_wr_cnt; dn0 = done_cnt;
        start_frame(1'b1, 22'd16, 22'd4);
        repeat (4) @(negedge clk);
        bus.aft_valid = 1'b1; bus.aft_endofpacket = 1'b1;
        bus.mode = 1'b0; bus.hist_total = 22'd1;
        @(negedge clk);
        bus.aft_valid = 1'b0; bus.aft_endofpacket = 1'b0;
        wait_done(6, cyc);
        check("cdf_done_cycles", 64'(cyc), 64'(DONE_CYC));
        repeat (30) @(negedge clk);
        check("cdf_writes", 64'(map_wr_cnt - wr0), 64'(N));
        check("cdf_done_pulses", 64'(done_cnt - dn0), 64'd1);
        check("cdf_idle", 64'(bus.busy), 64'd0);
        check_map("cdf");
        check_hist_clear("cdf");

        // Zero total: every map entry forced to 0.
        set_occ_pattern();
        for (int i = 0; i < N; i++) exp_map[i] = '0;
        load_hist();
        wr0 = map_wr_cnt;
        start_frame(1'b1, 22'd0, 22'd0);
        wait_done(1, cyc);
        check("zero_done_cycles", 64'(cyc), 64'(DONE_CYC));
        @(negedge clk);
        check("zero_writes", 64'(map_wr_cnt - wr0), 64'(N));
        check_map("zero");

        // Reset mid-RUN at read address 5, then a clean restart.
        set_occ_pattern();
        load_hist();
        start_frame(1'b0, 22'd3, 22'd0);
        guard = 0;
        while (bus.gray_ram_read_addr !== 4'd5 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_addr5", 64'(bus.gray_ram_read_addr), 64'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_map_write", 64'(bus.map_ram_write), 64'd0);
        check("abort_clear_write", 64'(bus.gray_ram_write), 64'd0);
        check("abort_read_addr", 64'(bus.gray_ram_read_addr), 64'd0);
        rst_n = 1'b1;
        load_hist();
        wr0 = map_wr_cnt; dn0 = done_cnt;
        start_frame(1'b0, 22'd3, 22'd0);
        check("restart_addr", 64'(bus.gray_ram_read_addr), 64'd0);
        wait_done(1, cyc);
        check("restart_done_cycles", 64'(cyc), 64'(DONE_CYC));
        @(negedge clk);
        check("restart_writes", 64'(map_wr_cnt - wr0), 64'(N));
        check("restart_done_pulses", 64'(done_cnt - dn0), 64'd1);
        check_map("restart");

        // Single heavy bin with clip 4: map saturates from bin 2 on in either build.
        for (int i = 0; i < N; i++) hist_init[i] = '0;
        hist_init[2] = 22'd12;
        for (int i = 0; i < N; i++) exp_map[i] = (i < 2) ? 10'd0 : 10'd1023;
        load_hist();
        start_frame(1'b1, 22'd4, 22'd4);
        wait_done(1, cyc);
        check("clip_done_cycles", 64'(cyc), 64'(DONE_CYC));
        @(negedge clk);
        check_map("clip");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
